seg7_display_arbiter: RTL and testbench
=======================================

# seg7_display_arbiter

Shares the 4-digit seven-segment display between two producers: the PS/2 mouse status path (requester 0, lossy, default owner) and the microprocessor bus (requester 1, lossless, priority with timed hold). Owns the digit-scan schedule and a tear-free frame shadow register, and feeds the seven-segment decoder with digit select, nibble, dot and blank. Sits between the PS/2 packet formatter and bus slave on the input side and the decoder on the output side.

## Interface

- REFRESH_DIV, 250000: clk_sys cycles per digit slot (200 Hz digit rate at 50 MHz); legal ≥ 2.
- HOLD_FRAMES, 50: frames the CPU keeps ownership after its last load (1 s at 50 Hz frame rate); legal 1..255.
- clk_sys  input  1  50 MHz system clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- req0_vld  input  1  mouse word valid.
- req0_data  input  16  mouse word, digit 3 = [15:12] … digit 0 = [3:0].
- req0_dots  input  4  mouse dot bits, bit i → digit i.
- req0_rdy  output  1  always 1 out of reset (latest-wins).
- req1_vld  input  1  CPU word valid.
- req1_data  input  16  CPU word, same mapping.
- req1_dots  input  4  CPU dot bits.
- req1_rdy  output  1  high when CPU pending buffer empty.
- owner  output  1  0 = mouse, 1 = CPU.
- seg_select  output  2  active digit index.
- bin  output  4  nibble for active digit.
- dot  output  1  dot for active digit.
- blank  output  1  active digit suppressed.
- frame_done  output  1  one-cycle pulse at each frame boundary.

## Operation

- Handshake: transfer on rising clk_sys when vld & rdy. Req0 transfer overwrites mouse_reg (data+dots). Req1 transfer writes cpu_buf and sets pend1; req1_rdy = !pend1.
- Refresh: div_cnt counts 0..REFRESH_DIV-1, wraps; tick when div_cnt == REFRESH_DIV-1. On tick seg_select increments mod 4. Frame boundary = tick while seg_select == 3; frame_done pulses that cycle.
- Shadow (16 data + 4 dots) changes only at a frame boundary, so a frame never mixes two words.
- Ownership FSM, evaluated at frame boundary only:
  - pend1 = 1: shadow ← cpu_buf, owner ← 1, hold_cnt ← HOLD_FRAMES, pend1 ← 0 (regardless of current owner).
  - else owner = 1 and hold_cnt > 1: hold_cnt decrements, shadow unchanged.
  - else owner = 1 and hold_cnt == 1: owner ← 0, hold_cnt ← 0, shadow ← mouse_reg.
  - else (owner = 0): shadow ← mouse_reg.
- Mouse words arriving during CPU hold are not queued; only the latest survives and appears at release.
- Output digit i: bin = shadow[4i+3:4i], dot = dots[i]; seg_select, bin, dot, blank registered together, always mutually consistent.
- Simultaneous req1 transfer and frame boundary: boundary uses pre-edge pend1; the new word loads at the next boundary. Same for req0.
- Reset values: req0_rdy 0 during reset then 1, req1_rdy 1, owner 0, seg_select 0, bin 0, dot 0, blank 0, frame_done 0, shadow/mouse_reg/cpu_buf 0, pend1 0, hold_cnt 0, div_cnt 0. Reset mid-hold or mid-frame discards pending CPU word.

## Timing

- Single clock domain, all outputs registered.
- Input-to-display latency: word visible on bin from the cycle after the first frame boundary following transfer; worst case 4·REFRESH_DIV + 1 cycles.
- Digit dwell exactly REFRESH_DIV cycles; frame exactly 4·REFRESH_DIV cycles.
- CPU ownership lasts HOLD_FRAMES full frames after load frame boundary; back-to-back CPU writes restart hold.
- req1_rdy returns high the cycle after the consuming frame boundary.

## Configuration

- SEG7_ARB_BLANK_EN defined: leading-zero blanking; blank = 1 for digit i when every shadow nibble j ≥ i is 0 and i ≠ 0 and dots[i] = 0. Digit 0 never blanked.
- Undefined: blank tied 0; all four digits always shown.

## Test plan

- Reset, REFRESH_DIV=4: seg_select cycles 0,1,2,3 each 4 cycles; frame_done every 16 cycles; outputs 0 during and after reset.
- Mouse word 0x12A4 dots 0x1 → after next frame_done, digit 0 shows 4 with dot=1, digit 3 shows 1; owner 0.
- CPU word 0xBEEF, HOLD_FRAMES=2 while mouse writes 0x0001 then 0x0002 → BEEF for 2 frames, then 0002 with owner 0; 0001 never shown.
- Two CPU writes back-to-back → second sees req1_rdy=0 until boundary; both words displayed in order, no loss.
- req1 transfer on the frame_done cycle → word appears one frame later, not that frame.
- With SEG7_ARB_BLANK_EN, shadow 0x0050 → digits 3,2 blank=1, digit 1 shows 5, digit 0 shows 0 blank=0; shadow 0x0000 → only digit 0 unblanked.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Two-requester arbiter for the 4-digit seven-segment display: mouse path (lossy, default owner)
// and CPU bus (lossless, timed hold), with digit scan and a frame-aligned shadow. Option: SEG7_ARB_BLANK_EN.
module seg7_display_arbiter #(
    parameter int REFRESH_DIV = 250000,
    parameter int HOLD_FRAMES = 50
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        req0_vld,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_dots,
    output logic        req0_rdy,
    input  logic        req1_vld,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_dots,
    output logic        req1_rdy,
    output logic        owner,
    output logic [1:0]  seg_select,
    output logic [3:0]  bin,
    output logic        dot,
    output logic        blank,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);

    // Ownership state; owner is this register, so the FSM state is directly observable.
    typedef enum logic {
        ST_MOUSE = 1'b0,
        ST_CPU   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_next_div;
    logic [1:0]  r_seg_select;
    logic [1:0]  w_next_seg;
    logic [15:0] r_shadow;
    logic [3:0]  r_shadow_dots;
    logic [15:0] w_next_shadow;
    logic [3:0]  w_next_dots;
    logic [15:0] r_mouse_data;
    logic [3:0]  r_mouse_dots;
    logic [15:0] r_cpu_data;
    logic [3:0]  r_cpu_dots;
    logic        r_pend1;
    logic        w_next_pend1;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_next_hold;
    logic        r_req0_rdy;
    logic        r_req1_rdy;
    logic [3:0]  r_bin;
    logic        r_dot;
    logic        r_blank;
    logic        w_next_blank;
    logic        r_frame_done;
    logic        w_xfer0;
    logic        w_xfer1;
    logic        w_tick;
    logic        w_boundary;
    logic        w_pre_boundary;

    // Handshake: a word transfers on the rising edge where vld and rdy are both high;
    // a producer holds vld and data stable until that edge.
    assign w_xfer0 = req0_vld & r_req0_rdy;
    assign w_xfer1 = req1_vld & r_req1_rdy;

    assign w_tick         = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_boundary     = w_tick && (r_seg_select == 2'd3);
    // frame_done is registered, so it is raised one cycle ahead of the boundary cycle.
    assign w_pre_boundary = (r_div_cnt == DIV_W'(REFRESH_DIV - 2)) && (r_seg_select == 2'd3);

    assign w_next_div = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    assign w_next_seg = w_tick ? r_seg_select + 2'd1 : r_seg_select;

    // A boundary sees the pre-edge pend1, so a word accepted on that same edge waits a frame.
    always_comb begin
        w_next_pend1 = r_pend1;
        if (r_pend1) begin
            if (w_boundary) w_next_pend1 = 1'b0;
        end else if (w_xfer1) begin
            w_next_pend1 = 1'b1;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_hold   = r_hold_cnt;
        w_next_shadow = r_shadow;
        w_next_dots   = r_shadow_dots;
        if (w_boundary) begin
            if (r_pend1) begin
                w_next_state  = ST_CPU;
                w_next_hold   = 8'(HOLD_FRAMES);
                w_next_shadow = r_cpu_data;
                w_next_dots   = r_cpu_dots;
            end else if (r_state == ST_CPU && r_hold_cnt > 8'd1) begin
                w_next_hold = r_hold_cnt - 8'd1;
            end else if (r_state == ST_CPU) begin
                w_next_state  = ST_MOUSE;
                w_next_hold   = 8'd0;
                w_next_shadow = r_mouse_data;
                w_next_dots   = r_mouse_dots;
            end else begin
                w_next_shadow = r_mouse_data;
                w_next_dots   = r_mouse_dots;
            end
        end
    end

`ifdef SEG7_ARB_BLANK_EN
    // Leading-zero suppression: digit i dark when it and everything above it is zero and it has no dot.
    always_comb begin
        w_next_blank = 1'b0;
        case (w_next_seg)
            2'd1:    w_next_blank = (w_next_shadow[15:4] == 12'd0) && !w_next_dots[1];
            2'd2:    w_next_blank = (w_next_shadow[15:8] == 8'd0) && !w_next_dots[2];
            2'd3:    w_next_blank = (w_next_shadow[15:12] == 4'd0) && !w_next_dots[3];
            default: w_next_blank = 1'b0;
        endcase
    end
`else
    assign w_next_blank = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state       <= ST_MOUSE;
            r_div_cnt     <= '0;
            r_seg_select  <= 2'd0;
            r_shadow      <= 16'd0;
            r_shadow_dots <= 4'd0;
            r_mouse_data  <= 16'd0;
            r_mouse_dots  <= 4'd0;
            r_cpu_data    <= 16'd0;
            r_cpu_dots    <= 4'd0;
            r_pend1       <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_req0_rdy    <= 1'b0;
            r_req1_rdy    <= 1'b1;
            r_bin         <= 4'd0;
            r_dot         <= 1'b0;
            r_blank       <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_div_cnt     <= w_next_div;
            r_seg_select  <= w_next_seg;
            r_shadow      <= w_next_shadow;
            r_shadow_dots <= w_next_dots;
            r_hold_cnt    <= w_next_hold;
            r_pend1       <= w_next_pend1;
            r_req0_rdy    <= 1'b1;
            r_req1_rdy    <= !w_next_pend1;
            r_frame_done  <= w_pre_boundary;
            if (w_xfer0) begin
                r_mouse_data <= req0_data;
                r_mouse_dots <= req0_dots;
            end
            if (w_xfer1) begin
                r_cpu_data <= req1_data;
                r_cpu_dots <= req1_dots;
            end
            // Digit outputs come from next-state values so they always match seg_select.
            r_bin   <= w_next_shadow[{w_next_seg, 2'b00} +: 4];
            r_dot   <= w_next_dots[w_next_seg];
            r_blank <= w_next_blank;
        end
    end

    assign req0_rdy   = r_req0_rdy;
    assign req1_rdy   = r_req1_rdy;
    assign owner      = r_state;
    assign seg_select = r_seg_select;
    assign bin        = r_bin;
    assign dot        = r_dot;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with REFRESH_DIV=4 (16-cycle frames) and HOLD_FRAMES=2.
module tb_seg7_display_arbiter;

    localparam int RDIV = 4;
    localparam int HOLD = 2;
`ifdef SEG7_ARB_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_vld = 1'b0;
    logic [15:0] req0_data = 16'd0;
    logic [3:0]  req0_dots = 4'd0;
    logic        req0_rdy;
    logic        req1_vld = 1'b0;
    logic [15:0] req1_data = 16'd0;
    logic [3:0]  req1_dots = 4'd0;
    logic        req1_rdy;
    logic        owner;
    logic [1:0]  seg_select;
    logic [3:0]  bin;
    logic        dot;
    logic        blank;
    logic        frame_done;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] cap_w;
    logic [3:0]  cap_d;
    logic [3:0]  cap_b;
    logic        cap_sel_ok;
    logic        cap_own;

    seg7_display_arbiter #(.REFRESH_DIV(RDIV), .HOLD_FRAMES(HOLD)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_data(req0_data), .req0_dots(req0_dots), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_data(req1_data), .req1_dots(req1_dots), .req1_rdy(req1_rdy),
        .owner(owner), .seg_select(seg_select), .bin(bin), .dot(dot), .blank(blank),
        .frame_done(frame_done)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send0(input logic [15:0] dv, input logic [3:0] tv);
        req0_vld  = 1'b1;
        req0_data = dv;
        req0_dots = tv;
        @(negedge clk_sys);
        req0_vld = 1'b0;
    endtask

    task automatic send1(input logic [15:0] dv, input logic [3:0] tv);
        bit done = 1'b0;
        req1_vld  = 1'b1;
        req1_data = dv;
        req1_dots = tv;
        for (int k = 0; k < 80; k++) begin
            if (req1_rdy === 1'b1) begin
                @(negedge clk_sys);
                done = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        req1_vld = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send1_timeout: req1_rdy stayed %b for 80 cycles, required 1", req1_rdy);
        end
    endtask

    task automatic wait_frame_done();
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_sys);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_done_timeout: no pulse in 40 cycles, required one");
        end
    endtask

    // Called in a boundary cycle; samples each digit of the following frame.
    task automatic capture(output logic [15:0] w, output logic [3:0] d, output logic [3:0] b,
                           output logic sel_ok, output logic own);
        w = 16'd0;
        d = 4'd0;
        b = 4'd0;
        sel_ok = 1'b1;
        @(negedge clk_sys);
        own = owner;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) repeat (RDIV) @(negedge clk_sys);
            if (seg_select !== 2'(i)) sel_ok = 1'b0;
            w[4*i +: 4] = bin;
            d[i] = dot;
            b[i] = blank;
        end
    endtask

    // Compares the last captured frame against expected values.
    task automatic frame_compare(input string name, input logic [15:0] ew, input logic [3:0] ed,
                                 input logic [3:0] eb, input logic eo);
        n_cmp++;
        if ({cap_sel_ok, cap_own, cap_w, cap_d, cap_b} !== {1'b1, eo, ew, ed, eb}) begin
            n_fail++;
            $display("FAIL %s: got sel_ok=%b owner=%b word=%h dots=%h blank=%b, expected sel_ok=1 owner=%b word=%h dots=%h blank=%b",
                     name, cap_sel_ok, cap_own, cap_w, cap_d, cap_b, eo, ew, ed, eb);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        n_cmp++;
        if ({seg_select, bin, dot, blank, frame_done, owner, req0_rdy, req1_rdy} !== 12'b0000_0000_0001) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%0d bin=%h dot=%b blank=%b fd=%b owner=%b rdy0=%b rdy1=%b, expected all 0 except rdy1=1",
                     seg_select, bin, dot, blank, frame_done, owner, req0_rdy, req1_rdy);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c != 0) @(negedge clk_sys);
            n_cmp++;
            if (seg_select !== 2'((c / RDIV) % 4)) begin
                n_fail++;
                $display("FAIL scan_select c=%0d: got %0d, expected %0d", c, seg_select, (c / RDIV) % 4);
            end
            n_cmp++;
            if (frame_done !== ((c % (4 * RDIV)) == (4 * RDIV - 1))) begin
                n_fail++;
                $display("FAIL scan_frame_done c=%0d: got %b, expected %b", c, frame_done,
                         (c % (4 * RDIV)) == (4 * RDIV - 1));
            end
            n_cmp++;
            if ({bin, dot, blank, owner} !== 7'd0) begin
                n_fail++;
                $display("FAIL scan_idle_outputs c=%0d: got bin=%h dot=%b blank=%b owner=%b, expected 0",
                         c, bin, dot, blank, owner);
            end
        end
        n_cmp++;
        if (req0_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL req0_rdy_after_reset: got %b, expected 1", req0_rdy);
        end
    endtask

    task automatic test_mouse();
        @(negedge clk_sys);
        send0(16'h12A4, 4'h1);
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("mouse_12a4", 16'h12A4, 4'h1, 4'b0000, 1'b0);
    endtask

    task automatic test_cpu_hold();
        send1(16'hBEEF, 4'h0);
        n_cmp++;
        if (req1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_pending_rdy: got %b, expected 0", req1_rdy);
        end
        send0(16'h0001, 4'h0);
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("cpu_hold_frame1", 16'hBEEF, 4'h0, 4'b0000, 1'b1);
        n_cmp++;
        if (req1_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_consumed_rdy: got %b, expected 1", req1_rdy);
        end
        send0(16'h0002, 4'h0);
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("cpu_hold_frame2", 16'hBEEF, 4'h0, 4'b0000, 1'b1);
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("cpu_release_latest_mouse", 16'h0002, 4'h0, BLANK_ON ? 4'b1110 : 4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        send1(16'h1111, 4'h3);
        n_cmp++;
        if (req1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_pending: got rdy=%b, expected 0", req1_rdy);
        end
        send1(16'h2222, 4'h4);
        n_cmp++;
        if ({seg_select, bin, dot, owner, req1_rdy} !== {2'd0, 4'h1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first_shown: got sel=%0d bin=%h dot=%b owner=%b rdy=%b, expected sel=0 bin=1 dot=1 owner=1 rdy=0",
                     seg_select, bin, dot, owner, req1_rdy);
        end
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("b2b_second_shown", 16'h2222, 4'h4, 4'b0000, 1'b1);
    endtask

    task automatic test_boundary_xfer();
        wait_frame_done();
        n_cmp++;
        if (req1_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_rdy: got %b, expected 1", req1_rdy);
        end
        req1_vld  = 1'b1;
        req1_data = 16'h3C3C;
        req1_dots = 4'h0;
        @(negedge clk_sys);
        req1_vld = 1'b0;
        n_cmp++;
        if ({seg_select, bin, owner, req1_rdy} !== {2'd0, 4'h2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bnd_not_this_frame: got sel=%0d bin=%h owner=%b rdy=%b, expected sel=0 bin=2 owner=1 rdy=0",
                     seg_select, bin, owner, req1_rdy);
        end
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("bnd_next_frame", 16'h3C3C, 4'h0, 4'b0000, 1'b1);
    endtask

    task automatic test_reset_mid_hold();
        send1(16'h7777, 4'hF);
        rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        n_cmp++;
        if ({owner, req1_rdy, seg_select, bin} !== {1'b0, 1'b1, 2'd0, 4'h0}) begin
            n_fail++;
            $display("FAIL midhold_reset: got owner=%b rdy1=%b sel=%0d bin=%h, expected owner=0 rdy1=1 sel=0 bin=0",
                     owner, req1_rdy, seg_select, bin);
        end
        rst_n = 1'b1;
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("midhold_discarded", 16'h0000, 4'h0, BLANK_ON ? 4'b1110 : 4'b0000, 1'b0);
    endtask

    task automatic test_blank();
        send0(16'h0050, 4'h0);
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("blank_0050", 16'h0050, 4'h0, BLANK_ON ? 4'b1100 : 4'b0000, 1'b0);
        send0(16'h0000, 4'h8);
        wait_frame_done();
        capture(cap_w, cap_d, cap_b, cap_sel_ok, cap_own);
        frame_compare("blank_dot_keeps_digit", 16'h0000, 4'h8, BLANK_ON ? 4'b0110 : 4'b0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mouse();
        test_cpu_hold();
        test_back_to_back();
        test_boundary_xfer();
        test_reset_mid_hold();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
